// File: rtl/conway_pkg.sv
// Shared definitions for the Life datapath: neighbour bit positions and
// the window generator state encoding.
package conway_pkg;

    localparam int NB_NW = 0;
    localparam int NB_N  = 1;
    localparam int NB_NE = 2;
    localparam int NB_W  = 3;
    localparam int NB_E  = 4;
    localparam int NB_SW = 5;
    localparam int NB_S  = 6;
    localparam int NB_SE = 7;

    typedef enum logic [1:0] {
        FILL,
        STREAM,
        FLUSH
    } window_state_t;

endpackage

// File: rtl/cell_window_shift.sv
// Serial-in shift register with parallel taps. taps[0] is the incoming cell and
// taps[j] the cell shifted in j enables ago, i.e. the contents as they will be after the edge.
module cell_window_shift #(
    parameter int LEN = 11
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           en,
    input  logic           din,
    output logic [LEN-1:0] taps
);

    logic [LEN-2:0] sr;

    // NOTE: the register is cleared on reset so that no cell from an abandoned
    // frame can ever be shifted into a window.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr <= '0;
        end else if (en) begin
            // NOTE: non-blocking, so every stage takes its neighbour's pre-edge value.
            sr <= {sr[LEN-3:0], din};
        end
    end

    assign taps = {sr, din};

endmodule

// File: rtl/neighbour_window.sv
// Raster-order Life window generator: emits each cell with its eight
// zero-padded neighbours, WIDTH+1 cells behind the input stream.
module neighbour_window
    import conway_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int HEIGHT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_cell,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_center,
    output logic [7:0] out_neighbours,
    output logic       out_last
);

    localparam int N   = WIDTH * HEIGHT;
    localparam int LEN = 2 * WIDTH + 3;
    localparam int CW  = $clog2(WIDTH);
    localparam int RW  = $clog2(HEIGHT);
    localparam int KW  = $clog2(N);

    window_state_t  state, state_nxt;
    logic [KW-1:0]  in_cnt;
    logic [CW-1:0]  out_col;
    logic [RW-1:0]  out_row;
    logic [LEN-1:0] taps;
    logic           can_load, load, accept, shift_en, din;
    logic           first_col, last_col, first_row, last_row;
    logic [7:0]     nb_raw, nb_masked;
    logic           unused_taps;

    assign can_load = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign shift_en = (state == FILL && in_valid) || load;
    assign din      = (state == FLUSH) ? 1'b0 : in_cell;

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        load      = 1'b0;
        unique case (state)
            FILL: begin
                in_ready = 1'b1;
                if (in_valid && in_cnt == KW'(WIDTH))
                    state_nxt = STREAM;
            end
            STREAM: begin
                in_ready = can_load;
                load     = in_valid && can_load;
                if (load && in_cnt == KW'(N - 1))
                    state_nxt = FLUSH;
            end
            FLUSH: begin
                // Once the final window sits in the register nothing more is loaded.
                load = can_load && !(out_valid && out_last);
                if (out_valid && out_last && out_ready)
                    state_nxt = FILL;
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= FILL;
            in_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (accept)
                in_cnt <= (in_cnt == KW'(N - 1)) ? '0 : in_cnt + KW'(1);
        end
    end

    cell_window_shift #(.LEN(LEN)) u_shift (
        .clk   (clk),
        .reset (reset),
        .en    (shift_en),
        .din   (din),
        .taps  (taps)
    );

    assign unused_taps = ^taps;

    // taps[0] is SE of the cell being loaded; centre sits WIDTH+1 behind it.
    always_comb begin
        nb_raw        = '0;
        nb_raw[NB_NW] = taps[2*WIDTH+2];
        nb_raw[NB_N]  = taps[2*WIDTH+1];
        nb_raw[NB_NE] = taps[2*WIDTH];
        nb_raw[NB_W]  = taps[WIDTH+2];
        nb_raw[NB_E]  = taps[WIDTH];
        nb_raw[NB_SW] = taps[2];
        nb_raw[NB_S]  = taps[1];
        nb_raw[NB_SE] = taps[0];
    end

    assign first_col = (out_col == '0);
    assign last_col  = (out_col == CW'(WIDTH - 1));
    assign first_row = (out_row == '0);
    assign last_row  = (out_row == RW'(HEIGHT - 1));

    // Row-0 masking also hides whatever the previous frame left in the register.
    always_comb begin
        nb_masked = nb_raw;
        if (first_col) begin
            nb_masked[NB_NW] = 1'b0;
            nb_masked[NB_W]  = 1'b0;
            nb_masked[NB_SW] = 1'b0;
        end
        if (last_col) begin
            nb_masked[NB_NE] = 1'b0;
            nb_masked[NB_E]  = 1'b0;
            nb_masked[NB_SE] = 1'b0;
        end
        if (first_row) begin
            nb_masked[NB_NW] = 1'b0;
            nb_masked[NB_N]  = 1'b0;
            nb_masked[NB_NE] = 1'b0;
        end
        if (last_row) begin
            nb_masked[NB_SW] = 1'b0;
            nb_masked[NB_S]  = 1'b0;
            nb_masked[NB_SE] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_col <= '0;
            out_row <= '0;
        end else if (load) begin
            if (last_col) begin
                out_col <= '0;
                out_row <= last_row ? '0 : out_row + RW'(1);
            end else begin
                out_col <= out_col + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid      <= 1'b0;
            out_center     <= 1'b0;
            out_neighbours <= '0;
            out_last       <= 1'b0;
        end else if (load) begin
            out_valid      <= 1'b1;
            out_center     <= taps[WIDTH+1];
            out_neighbours <= nb_masked;
            out_last       <= last_row && last_col;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule
